hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_sb_src_check.sv | 28 ++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared core defines for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int NREG_DEF         = 32;
  localparam int AW_DEF           = 5;
  localparam int NSRC_DEF         = 2;
  localparam int MAX_INFLIGHT_DEF = 4;

  // Register x0 is hardwired: it is never pending, never hazards, never forwards.
  localparam int ZERO_REG = 0;

  // Saturating 16-bit increment used for the stall statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_src_check.sv
// rtl/hazard_scoreboard_sb_src_check.sv - RAW / forward decision for one source operand
module sb_src_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            src_use,
  input  logic [AW-1:0]   src_addr,
  input  logic [NREG-1:0] busy_vec,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            raw,
  output logic            fwd
);

  logic live;
  logic wb_match;

  // A pending source either stalls or, if its writer retires this cycle, takes the bypass.
  always_comb begin
    live     = src_use & (src_addr != AW'(ZERO_REG)) & busy_vec[src_addr];
    wb_match = wb_valid & (wb_rd == src_addr);
    raw      = live & ~wb_match;
    fwd      = live & wb_match;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register write scoreboard with RAW/WAW/full stall and bypass select
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG         = NREG_DEF,
  parameter int AW           = AW_DEF,
  parameter int NSRC         = NSRC_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               iss_valid,
  output logic                               iss_ready,
  input  logic                               iss_we,
  input  logic [AW-1:0]                      iss_rd,
  input  logic [NSRC*AW-1:0]                 iss_src,
  input  logic [NSRC-1:0]                    iss_src_use,
  input  logic                               wb_valid,
  input  logic [AW-1:0]                      wb_rd,
  output logic                               stall,
  output logic [NSRC-1:0]                    fwd_sel,
  output logic [NREG-1:0]                    busy_vec,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
  output logic [15:0]                        stall_cnt
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] MAX_V = IW'(MAX_INFLIGHT);

  logic [NREG-1:0] busy_q, busy_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [NSRC-1:0] raw_vec;
  logic            rd_nz;
  logic            wb_hit;
  logic            waw;
  logic            full;
  logic            do_set;

  // One RAW/forward checker per source read port.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    sb_src_check #(
      .NREG (NREG),
      .AW   (AW)
    ) u_chk (
      .src_use  (iss_src_use[i]),
      .src_addr (iss_src[i*AW +: AW]),
      .busy_vec (busy_q),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .raw      (raw_vec[i]),
      .fwd      (fwd_sel[i])
    );
  end

  // Zero-latency issue decision from the current scoreboard and this cycle's writeback.
  always_comb begin
    rd_nz     = (iss_rd != AW'(ZERO_REG));
    wb_hit    = wb_valid & busy_q[wb_rd];
    waw       = iss_we & rd_nz & busy_q[iss_rd] & ~(wb_hit & (wb_rd == iss_rd));
    full      = (inflight_q == MAX_V) & ~wb_hit;
    stall     = iss_valid & ~flush & ((|raw_vec) | waw | (iss_we & full));
    iss_ready = ~stall;
    do_set    = iss_valid & ~stall & iss_we & rd_nz;
  end

  // Next scoreboard state: clear on writeback, set on issue (set wins), flush overrides both.
  always_comb begin
    busy_d      = busy_q;
    inflight_d  = inflight_q;
    stall_cnt_d = stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;
    if (wb_hit) busy_d[wb_rd] = 1'b0;
    if (do_set) busy_d[iss_rd] = 1'b1;
    if (do_set && !wb_hit) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!do_set && wb_hit) begin
      inflight_d = inflight_q - IW'(1);
    end
    if (flush) begin
      busy_d     = '0;
      inflight_d = '0;
    end
  end

  // State registers; reset discards every pending write and the stall statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_vec  = busy_q;
  assign inflight  = inflight_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic        iss_we;
  logic [4:0]  iss_rd;
  logic [9:0]  iss_src;
  logic [1:0]  iss_src_use;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [1:0]  fwd_sel;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: set of pending registers plus the stall statistic.
  bit pend[32];
  int m_cnt;
  bit m_stall;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_we      (iss_we),
    .iss_rd      (iss_rd),
    .iss_src     (iss_src),
    .iss_src_use (iss_src_use),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .busy_vec    (busy_vec),
    .inflight    (inflight),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pend_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += pend[r];
    return n;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = pend[r];
    return v;
  endfunction

  task automatic model_clear_all();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs and compare every output with the model's prediction.
  task automatic cyc(input bit v, input bit we, input int rd, input int s0, input int s1,
                     input bit [1:0] use_m, input bit wbv, input int wbrd, input bit fl);
    bit wmatch[2];
    bit raw_any, waw, full, fwd0, fwd1;
    int a[2];
    iss_valid   = v;
    iss_we      = we;
    iss_rd      = rd[4:0];
    iss_src     = {s1[4:0], s0[4:0]};
    iss_src_use = use_m;
    wb_valid    = wbv;
    wb_rd       = wbrd[4:0];
    flush       = fl;
    #1;
    a[0] = s0; a[1] = s1;
    raw_any = 0;
    for (int i = 0; i < 2; i++) begin
      wmatch[i] = wbv && (wbrd == a[i]);
      if (use_m[i] && a[i] != 0 && pend[a[i]] && !wmatch[i]) raw_any = 1;
    end
    fwd0 = use_m[0] && a[0] != 0 && pend[a[0]] && wmatch[0];
    fwd1 = use_m[1] && a[1] != 0 && pend[a[1]] && wmatch[1];
    waw  = we && rd != 0 && pend[rd] && !(wbv && wbrd == rd);
    full = (pend_count() == 4) && !(wbv && pend[wbrd]);
    m_stall = v && !fl && (raw_any || waw || (we && full));
    chk("stall",     {31'd0, stall},     {31'd0, m_stall});
    chk("iss_ready", {31'd0, iss_ready}, {31'd0, !m_stall});
    chk("fwd_sel",   {30'd0, fwd_sel},   {30'd0, fwd1, fwd0});
    chk("busy_vec",  busy_vec,           pend_vec());
    chk("inflight",  {29'd0, inflight},  pend_count());
    chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    if (!rst_n) begin
      model_clear_all();
    end else begin
      if (m_stall && m_cnt < 16'hFFFF) m_cnt++;
      if (flush) begin
        for (int r = 0; r < 32; r++) pend[r] = 0;
      end else begin
        if (wb_valid && pend[wb_rd]) pend[wb_rd] = 0;
        if (iss_valid && !m_stall && iss_we && iss_rd != 0) pend[iss_rd] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    tick();
  endtask

  initial begin
    model_clear_all();
    rst_n = 1'b0;
    // Reset state, with an active request presented
    cyc(1, 1, 5, 5, 6, 2'b11, 1, 5, 0);
    chk("rst_ready", {31'd0, iss_ready}, 1);
    tick();
    rst_n = 1'b1;

    // RAW on x5: stall without writeback, bypass when it retires
    cyc(1, 1, 5, 0, 0, 2'b00, 0, 0, 0); tick();
    cyc(1, 0, 0, 5, 0, 2'b01, 0, 0, 0);
    chk("raw_stall", {31'd0, stall}, 1);
    tick();
    chk("raw_cnt", {16'd0, stall_cnt}, 1);
    cyc(1, 0, 0, 5, 0, 2'b01, 1, 5, 0);
    chk("raw_fwd_stall", {31'd0, stall}, 0);
    chk("raw_fwd_sel", {30'd0, fwd_sel}, 1);
    tick();

    // x0 is never pending
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0); tick();
    cyc(1, 0, 0, 0, 0, 2'b11, 0, 0, 0);
    chk("x0_busy", busy_vec, 0);
    chk("x0_stall", {31'd0, stall}, 0);
    tick();

    // WAW on x7, then set-wins with simultaneous writeback
    do_flush();
    cyc(1, 1, 7, 0, 0, 2'b00, 0, 0, 0); tick();
    cyc(1, 1, 7, 0, 0, 2'b00, 0, 0, 0);
    chk("waw_stall", {31'd0, stall}, 1);
    tick();
    cyc(1, 1, 7, 0, 0, 2'b00, 1, 7, 0); tick();
    chk("setwin_busy7", {31'd0, busy_vec[7]}, 1);
    chk("setwin_inflight", {29'd0, inflight}, 1);

    // Full: four writes, fifth stalls, accepted when a writeback frees a slot
    do_flush();
    for (int r = 1; r <= 4; r++) begin
      cyc(1, 1, r, 0, 0, 2'b00, 0, 0, 0); tick();
    end
    cyc(1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
    chk("full_stall", {31'd0, stall}, 1);
    tick();
    cyc(1, 1, 9, 0, 0, 2'b00, 1, 1, 0);
    chk("full_wb_accept", {31'd0, iss_ready}, 1);
    tick();
    chk("full_inflight", {29'd0, inflight}, 4);

    // Flush with a simultaneous issue
    do_flush();
    for (int r = 10; r <= 12; r++) begin
      cyc(1, 1, r, 0, 0, 2'b00, 0, 0, 0); tick();
    end
    cyc(1, 1, 8, 0, 0, 2'b00, 1, 10, 1); tick();
    chk("flush_busy", busy_vec, 0);
    chk("flush_inflight", {29'd0, inflight}, 0);

    // Reset mid-operation, then a stray writeback
    cyc(1, 1, 2, 0, 0, 2'b00, 0, 0, 0); tick();
    cyc(1, 1, 3, 0, 0, 2'b00, 0, 0, 0); tick();
    rst_n = 1'b0;
    #1;
    model_clear_all();
    cyc(1, 0, 0, 2, 3, 2'b11, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 2'b00, 1, 3, 0); tick();
    chk("stray_wb_inflight", {29'd0, inflight}, 0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 31) == 0);
      tick();
    end
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
